// File: rtl/bitcount_seq.sv
// Sequential bit statistics: popcount, highest-set position, trailing or leading zeros,
// scanned CHUNK bits per clock. Define BITCOUNT_SYNC_EN to pass STARTBTN through a 2-flop synchronizer.
module bitcount_seq #(
  parameter int WIDTH = 10,
  parameter int CHUNK = 1,
  localparam int OUT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STARTBTN,
  input  logic [WIDTH-1:0] NUM,
  input  logic [1:0]       MODE,
  output logic [OUT_W-1:0] HBITS,
  output logic             BUSY,
  output logic             DONE,
  output logic             ZERO
);

  if ((WIDTH < 2) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_param_err
    $error("bitcount_seq: WIDTH must be >= 2 and CHUNK must divide WIDTH");
  end

  localparam int unsigned CHUNK_U = CHUNK;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic btn_s, btn_prev_q, start_edge;

`ifdef BITCOUNT_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= STARTBTN;
      sync2_q <= sync1_q;
    end
  end

  assign btn_s = sync2_q;
`else
  assign btn_s = STARTBTN;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) btn_prev_q <= 1'b0;
    else       btn_prev_q <= btn_s;
  end

  assign start_edge = btn_s & ~btn_prev_q;

  logic [WIDTH-1:0] sh_q, sh_d;
  logic [1:0]       m_q, m_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] pos_q, pos_d;
  logic             seen_q, seen_d;
  logic [OUT_W-1:0] hbits_q, hbits_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [OUT_W-1:0] acc_v;
  logic [OUT_W-1:0] idx_v;
  logic             seen_v;
  logic             bit_v;

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_edge) state_d = RUN;
      RUN:     if (pos_q == OUT_W'(WIDTH - CHUNK)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next-values
  always_comb begin
    sh_d    = sh_q;
    m_d     = m_q;
    acc_d   = acc_q;
    pos_d   = pos_q;
    seen_d  = seen_q;
    hbits_d = hbits_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    acc_v   = acc_q;
    seen_v  = seen_q;
    idx_v   = '0;
    bit_v   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          sh_d   = NUM;
          m_d    = MODE;
          acc_d  = '0;
          pos_d  = '0;
          seen_d = 1'b0;
          busy_d = 1'b1;
        end
      end
      RUN: begin
        // Lower index first, so trailing-zero counting stops mid-chunk at the first one
        for (int unsigned j = 0; j < CHUNK_U; j++) begin
          bit_v = sh_q[j];
          idx_v = pos_q + OUT_W'(j);
          case (m_q)
            2'b00:        if (bit_v) acc_v = acc_v + OUT_W'(1);
            2'b01, 2'b11: if (bit_v) acc_v = idx_v + OUT_W'(1);
            default:      if (!seen_v && !bit_v) acc_v = acc_v + OUT_W'(1);
          endcase
          if (bit_v) seen_v = 1'b1;
        end
        acc_d  = acc_v;
        seen_d = seen_v;
        sh_d   = sh_q >> CHUNK;
        pos_d  = pos_q + OUT_W'(CHUNK);
      end
      FIN: begin
        hbits_d = (m_q == 2'b11) ? (OUT_W'(WIDTH) - acc_q) : acc_q;
        zero_d  = ~seen_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sh_q    <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      pos_q   <= '0;
      seen_q  <= 1'b0;
      hbits_q <= '0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      pos_q   <= pos_d;
      seen_q  <= seen_d;
      hbits_q <= hbits_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign HBITS = hbits_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign ZERO  = zero_q;

endmodule

// File: tb/tb_bitcount_seq.sv
// Scoreboard bench for bitcount_seq: a 10x1 and a 16x4 instance driven with directed vectors.
module tb_bitcount_seq;

`ifdef BITCOUNT_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        st_a, st_b;
  logic [9:0]  num_a;
  logic [15:0] num_b;
  logic [1:0]  mode_a, mode_b;
  logic [3:0]  hb_a;
  logic [4:0]  hb_b;
  logic        busy_a, done_a, zero_a;
  logic        busy_b, done_b, zero_b;

  bitcount_seq #(.WIDTH(10), .CHUNK(1)) u_a (
    .CLK(clk), .RESET(rst), .STARTBTN(st_a), .NUM(num_a), .MODE(mode_a),
    .HBITS(hb_a), .BUSY(busy_a), .DONE(done_a), .ZERO(zero_a)
  );

  bitcount_seq #(.WIDTH(16), .CHUNK(4)) u_b (
    .CLK(clk), .RESET(rst), .STARTBTN(st_b), .NUM(num_b), .MODE(mode_b),
    .HBITS(hb_b), .BUSY(busy_b), .DONE(done_b), .ZERO(zero_b)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int h;
    bit z;
    int c;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic on_done(input int sel, input int h, input bit z, input int bc);
    exp_t e;
    int   qsz;
    qsz = (sel == 0) ? qa.size() : qb.size();
    if (qsz == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_done dut%0d: got DONE with HBITS=%0d, expected no DONE (cycle %0d)",
               sel, h, cyc);
      return;
    end
    if (sel == 0) e = qa.pop_front();
    else          e = qb.pop_front();
    chk((sel == 0) ? "a_hbits" : "b_hbits", h, e.h);
    chk((sel == 0) ? "a_zero" : "b_zero", int'(z), int'(e.z));
    chk((sel == 0) ? "a_done_cycle" : "b_done_cycle", cyc, e.c);
    chk((sel == 0) ? "a_busy_cycles" : "b_busy_cycles", bc, (sel == 0) ? 11 : 5);
  endtask

  // Monitor: pops the scoreboard whenever DONE is seen; counts BUSY-high cycles per scan
  initial begin
    int bca;
    int bcb;
    bca = 0;
    bcb = 0;
    forever begin
      @(negedge clk);
      if (done_a) begin
        on_done(0, int'(hb_a), zero_a, bca);
        bca = 0;
      end else if (busy_a) bca++;
      else bca = 0;
      if (done_b) begin
        on_done(1, int'(hb_b), zero_b, bcb);
        bcb = 0;
      end else if (busy_b) bcb++;
      else bcb = 0;
    end
  end

  task automatic press(input int sel, input logic [15:0] num, input logic [1:0] mode,
                       input int h, input bit z, input int hold, input bit expect_done);
    exp_t e;
    @(negedge clk);
    if (sel == 0) begin
      num_a  = num[9:0];
      mode_a = mode;
      st_a   = 1'b1;
    end else begin
      num_b  = num;
      mode_b = mode;
      st_b   = 1'b1;
    end
    e.h = h;
    e.z = z;
    e.c = cyc + ((sel == 0) ? 10 : 4) + 2 + EXTRA;
    if (expect_done) begin
      if (sel == 0) qa.push_back(e);
      else          qb.push_back(e);
    end
    repeat (hold) @(negedge clk);
    if (sel == 0) st_a = 1'b0;
    else          st_b = 1'b0;
  endtask

  task automatic drain(input int sel);
    int qsz;
    qsz = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      qsz = (sel == 0) ? qa.size() : qb.size();
      if (qsz == 0) break;
    end
    chk((sel == 0) ? "a_done_timeout" : "b_done_timeout", qsz, 0);
    if (sel == 0) qa.delete();
    else          qb.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst    = 1'b1;
    st_a   = 1'b0;
    st_b   = 1'b0;
    num_a  = '0;
    num_b  = '0;
    mode_a = '0;
    mode_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_hbits_a", int'(hb_a), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_done_a", int'(done_a), 0);
    chk("rst_zero_a", int'(zero_a), 0);
    chk("rst_hbits_b", int'(hb_b), 0);
    chk("rst_busy_b", int'(busy_b), 0);
    chk("rst_done_b", int'(done_b), 0);
    chk("rst_zero_b", int'(zero_b), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    press(0, 16'h000A, 2'b00, 2, 1'b0, 2, 1'b1);
    drain(0);

    // Switches alone must not disturb the held result
    num_a = 10'h3FE;
    repeat (10) @(negedge clk);
    chk("hold_hbits_a", int'(hb_a), 2);
    chk("hold_busy_a", int'(busy_a), 0);
    press(0, 16'h03FE, 2'b00, 9, 1'b0, 2, 1'b1);
    drain(0);

    press(0, 16'h000A, 2'b01, 4, 1'b0, 2, 1'b1);
    drain(0);
    press(0, 16'h000A, 2'b10, 1, 1'b0, 2, 1'b1);
    drain(0);
    press(0, 16'h000A, 2'b11, 6, 1'b0, 2, 1'b1);
    drain(0);
    press(0, 16'h0000, 2'b10, 10, 1'b1, 2, 1'b1);
    drain(0);
    press(0, 16'h0000, 2'b01, 0, 1'b1, 2, 1'b1);
    drain(0);

    press(1, 16'h8001, 2'b00, 2, 1'b0, 2, 1'b1);
    drain(1);
    press(1, 16'h0040, 2'b10, 6, 1'b0, 2, 1'b1);
    drain(1);
    press(1, 16'hFFFF, 2'b11, 0, 1'b0, 2, 1'b1);
    drain(1);

    // Second press while scanning: ignored, operand change ignored too
    press(0, 16'h000A, 2'b00, 2, 1'b0, 1, 1'b1);
    repeat (2) @(negedge clk);
    press(0, 16'h03FF, 2'b00, 0, 1'b0, 1, 1'b0);
    drain(0);
    repeat (25) @(negedge clk);

    // Button held for 50 cycles gives one scan
    press(0, 16'h03FF, 2'b00, 10, 1'b0, 50, 1'b1);
    drain(0);
    repeat (25) @(negedge clk);

    // Reset mid-scan aborts with no DONE
    press(0, 16'h0155, 2'b00, 0, 1'b0, 2, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy_a", int'(busy_a), 0);
    chk("abort_hbits_a", int'(hb_a), 0);
    chk("abort_done_a", int'(done_a), 0);
    chk("abort_zero_a", int'(zero_a), 0);
    repeat (20) @(negedge clk);
    press(0, 16'h000A, 2'b01, 4, 1'b0, 2, 1'b1);
    drain(0);

    repeat (5) @(negedge clk);
    chk("left_in_queue_a", qa.size(), 0);
    chk("left_in_queue_b", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
